if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and generates next-PC with redirect priority: exception > interrupt > branch > jump > sequential.
- Drives a variable-latency instruction-memory request/ready handshake.
- Presents IF_PC_4, IF_Instruct and IF_valid, registered, to IF/ID; emits a zero (nop) bubble whenever no valid word is available.

---
 rtl/if_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and registers IF_PC_4/IF_Instruct/IF_valid.
// Optional macro SUPERVISOR_BIT_EN treats pc[31] as a supervisor bit (masks irq, pins bit 31 on sequential/branch).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exception,
    input  logic        irq,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_PC_4,
    output logic [31:0] IF_Instruct,
    output logic        IF_valid
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t      r_state, w_stateNext;
    logic [31:0] r_pc, r_hold, r_redirPc, r_ifPc4, r_ifInstr;
    logic        r_ifValid;
    logic [31:0] w_pcNext, w_holdNext, w_redirNext, w_ifPc4Next, w_ifInstrNext;
    logic        w_ifValidNext;
    logic        w_irqEff, w_redirect;
    logic [31:0] w_pcPlus4, w_brTarget, w_jmpTarget, w_target;

`ifdef SUPERVISOR_BIT_EN
    // User code cannot raise its own privilege; only a jump from supervisor may clear/keep bit 31 freely.
    assign w_irqEff    = irq & ~r_pc[31];
    assign w_pcPlus4   = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_brTarget  = {r_pc[31], branch_target[30:0]};
    assign w_jmpTarget = {r_pc[31] & jump_target[31], jump_target[30:0]};
`else
    assign w_irqEff    = irq;
    assign w_pcPlus4   = r_pc + 32'd4;
    assign w_brTarget  = branch_target;
    assign w_jmpTarget = jump_target;
`endif

    assign w_redirect = exception | w_irqEff | branch_taken | jump;

    always_comb begin
        w_target = w_jmpTarget;
        if (exception)
            w_target = EXC_VEC;
        else if (w_irqEff)
            w_target = IRQ_VEC;
        else if (branch_taken)
            w_target = w_brTarget;
        w_target[1:0] = 2'b00;
    end

    assign imem_req    = (r_state != ST_HOLD) & ~reset;
    assign imem_addr   = r_pc;
    assign IF_PC_4     = r_ifPc4;
    assign IF_Instruct = r_ifInstr;
    assign IF_valid    = r_ifValid;

    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_holdNext    = r_hold;
        w_redirNext   = r_redirPc;
        w_ifPc4Next   = r_ifPc4;
        w_ifInstrNext = r_ifInstr;
        w_ifValidNext = r_ifValid;
        case (r_state)
            ST_REQ: begin
                if (w_redirect) begin
                    w_ifPc4Next   = '0;
                    w_ifInstrNext = '0;
                    w_ifValidNext = 1'b0;
                    if (imem_ready) begin
                        w_pcNext = w_target;
                    end else begin
                        w_redirNext = w_target;
                        w_stateNext = ST_KILL;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        w_ifPc4Next   = w_pcPlus4;
                        w_ifInstrNext = imem_rdata;
                        w_ifValidNext = 1'b1;
                        w_pcNext      = w_pcPlus4;
                    end else begin
                        w_holdNext  = imem_rdata;
                        w_stateNext = ST_HOLD;
                    end
                end else if (!stall) begin
                    w_ifPc4Next   = '0;
                    w_ifInstrNext = '0;
                    w_ifValidNext = 1'b0;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_ifPc4Next   = '0;
                    w_ifInstrNext = '0;
                    w_ifValidNext = 1'b0;
                    w_pcNext      = w_target;
                    w_holdNext    = '0;
                    w_stateNext   = ST_REQ;
                end else if (!stall) begin
                    w_ifPc4Next   = w_pcPlus4;
                    w_ifInstrNext = r_hold;
                    w_ifValidNext = 1'b1;
                    w_pcNext      = w_pcPlus4;
                    w_stateNext   = ST_REQ;
                end
            end
            ST_KILL: begin
                // The old request must still complete; its data is thrown away and the newest redirect wins.
                w_ifPc4Next   = '0;
                w_ifInstrNext = '0;
                w_ifValidNext = 1'b0;
                if (w_redirect)
                    w_redirNext = w_target;
                if (imem_ready) begin
                    w_pcNext    = w_redirect ? w_target : r_redirPc;
                    w_stateNext = ST_REQ;
                end
            end
            default: w_stateNext = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_REQ;
            r_pc      <= RESET_PC;
            r_hold    <= '0;
            r_redirPc <= '0;
            r_ifPc4   <= '0;
            r_ifInstr <= '0;
            r_ifValid <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_hold    <= w_holdNext;
            r_redirPc <= w_redirNext;
            r_ifPc4   <= w_ifPc4Next;
            r_ifInstr <= w_ifInstrNext;
            r_ifValid <= w_ifValidNext;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a transaction-level fetch model pushes expected IF outputs, a monitor pops them.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, exception = 1'b0, irq = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_PC_4, IF_Instruct;
    logic        IF_valid;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifOut_t;

    ifOut_t      expQ[$];
    ifOut_t      holdQ[$];
    ifOut_t      lastExp;
    logic [31:0] mPc, mRedirTo;
    bit          mDead;
    int          total = 0;
    int          bad = 0;

    if_fetch_stage #(
        .RESET_PC(RESET_PC), .IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .exception(exception), .irq(irq),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .IF_PC_4(IF_PC_4), .IF_Instruct(IF_Instruct), .IF_valid(IF_valid)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address so every fetched word identifies its source.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    function automatic logic [31:0] seqInc(input logic [31:0] p);
`ifdef SUPERVISOR_BIT_EN
        return {p[31], p[30:0] + 31'd4};
`else
        return p + 32'd4;
`endif
    endfunction

    function automatic logic [31:0] pickTarget(input logic [31:0] pc, input bit exc, input bit irqOn,
                                               input bit br, input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] t;
        if (exc)        t = EXC_VEC;
        else if (irqOn) t = IRQ_VEC;
        else if (br)    t = bt;
        else            t = jt;
`ifdef SUPERVISOR_BIT_EN
        if (!exc && !irqOn) t[31] = br ? pc[31] : (pc[31] & jt[31]);
`endif
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one fetch transaction at a time, a one-entry queue for a word parked by stall,
    // and a flag for a request that is already doomed by a redirect.
    task automatic modelStep(input bit s, input bit rdy, input bit exc, input bit irqIn,
                             input bit br, input logic [31:0] bt, input bit jm, input logic [31:0] jt);
        bit          irqOn, redirect, req;
        logic [31:0] t;
        ifOut_t      nxt, w;
        irqOn = irqIn;
`ifdef SUPERVISOR_BIT_EN
        irqOn = irqIn && !mPc[31];
`endif
        redirect = exc || irqOn || br || jm;
        req = (holdQ.size() == 0);
        nxt = lastExp;
        if (redirect) begin
            t = pickTarget(mPc, exc, irqOn, br, bt, jt);
            holdQ.delete();
            if (req && !rdy) begin
                mDead = 1'b1;
                mRedirTo = t;
            end else begin
                mDead = 1'b0;
                mPc = t;
            end
            nxt = '0;
        end else if (mDead) begin
            if (rdy) begin
                mDead = 1'b0;
                mPc = mRedirTo;
            end
            nxt = '0;
        end else if (!req) begin
            if (!s) begin
                nxt = holdQ.pop_front();
                mPc = seqInc(mPc);
            end
        end else if (rdy) begin
            w = '{pc4: seqInc(mPc), instr: memWord(mPc), valid: 1'b1};
            if (!s) begin
                nxt = w;
                mPc = seqInc(mPc);
            end else begin
                holdQ.push_back(w);
            end
        end else if (!s) begin
            nxt = '0;
        end
        expQ.push_back(nxt);
        lastExp = nxt;
    endtask

    task automatic applyStimulus(input bit s, input bit rdy, input bit exc, input bit irqIn,
                                 input bit br, input logic [31:0] bt, input bit jm, input logic [31:0] jt);
        @(negedge clk);
        reset = 1'b0;
        stall = s; imem_ready = rdy; exception = exc; irq = irqIn;
        branch_taken = br; branch_target = bt; jump = jm; jump_target = jt;
        #1;
        checkOutput("imemReq", {31'b0, imem_req}, {31'b0, (holdQ.size() == 0)});
        checkOutput("imemAddr", imem_addr, mPc);
        modelStep(s, rdy, exc, irqIn, br, bt, jm, jt);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0; imem_ready = 1'b0; exception = 1'b0; irq = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        #1;
        checkOutput("rstValid", {31'b0, IF_valid}, 32'd0);
        checkOutput("rstInstr", IF_Instruct, 32'd0);
        checkOutput("rstPc4", IF_PC_4, 32'd0);
        checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
        checkOutput("rstAddr", imem_addr, RESET_PC);
        mPc = RESET_PC;
        mRedirTo = '0;
        mDead = 1'b0;
        holdQ.delete();
        lastExp = '0;
        @(posedge clk);
    endtask

    // Monitor: every clock out of reset the DUT presents one IF word that must match the next expectation.
    initial begin
        ifOut_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreboardUnderflow: got empty queue expected an entry at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ifValid", {31'b0, IF_valid}, {31'b0, e.valid});
                    checkOutput("ifInstr", IF_Instruct, e.instr);
                    checkOutput("ifPc4", IF_PC_4, e.pc4);
                end
            end
        end
    end

    initial begin
        doReset();

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("firstPc4", IF_PC_4, 32'h8000_0004);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("secondPc4", IF_PC_4, 32'h8000_0008);
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("waitPc4", IF_PC_4, 32'h8000_0014);

        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0100, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("killTarget", imem_addr, 32'h8000_0100);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 1, 1, 1, 32'h8000_0200, 0, 0);
        @(posedge clk); #2;
        checkOutput("excPriority", imem_addr, 32'h8000_0008);

        applyStimulus(0, 1, 0, 0, 1, 32'hFFFF_FFFA, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

`ifdef SUPERVISOR_BIT_EN
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h0040_0000);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("supIrqTaken", imem_addr, 32'h8000_0004);
        applyStimulus(0, 1, 0, 0, 1, 32'h0000_0020, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("supIrqMasked", imem_addr, 32'h8000_0024);
`endif

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        doReset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                              $urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
                              $urandom_range(0, 11) == 0, $urandom(),
                              $urandom_range(0, 14) == 0, $urandom());
            end
        end

        @(posedge clk); #2;
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
